// File: rtl/md_sequencer_if.sv
// Issue/result bundle between the EX-stage issue logic and md_sequencer.
// The master issues MD operations with forwarded operands; the slave
// reports busy/stall and the architectural HI/LO registers.
interface md_sequencer_if;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_op, rs_val, rt_val,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  md_op, rs_val, rt_val,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer for the EX stage.
// The result is computed at issue and parked in pend_hi/pend_lo; a
// down-counter then models the multi-cycle latency before HI/LO commit.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

  logic [4:0]  cnt_q,     cnt_d;
  logic [31:0] hi_q,      hi_d;
  logic [31:0] lo_q,      lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;

  state_t      state;
  logic        start_op;

  // Arithmetic datapath
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_signed;
  logic               a_neg;
  logic               b_neg;
  logic        [31:0] div_a;
  logic        [31:0] div_b;
  logic        [31:0] div_b_safe;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic        [31:0] div_q;
  logic        [31:0] div_r;

  // Decode the two-state controller directly from the counter
  always_comb begin
    state    = (cnt_q != '0) ? RUN : IDLE;
    start_op = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU) ||
               (bus.md_op == OP_DIV)  || (bus.md_op == OP_DIVU);
  end

  // Full-width products from sign- or zero-extended operands
  always_comb begin
    prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val}) *
             $signed({{32{bus.rt_val[31]}}, bus.rt_val});
    prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
  end

  // Divide on magnitudes, then fix signs: quotient truncates toward zero,
  // remainder follows the dividend. Doing it this way makes
  // 0x80000000 / -1 wrap to 0x80000000 without relying on tool behaviour.
  always_comb begin
    div_signed = (bus.md_op == OP_DIV);
    a_neg      = div_signed && bus.rs_val[31];
    b_neg      = div_signed && bus.rt_val[31];
    div_a      = a_neg ? (32'd0 - bus.rs_val) : bus.rs_val;
    div_b      = b_neg ? (32'd0 - bus.rt_val) : bus.rt_val;
    // Keep the divider well-defined on a zero divisor; its result is unused then
    div_b_safe = (div_b == '0) ? 32'd1 : div_b;
    uq         = div_a / div_b_safe;
    ur         = div_a % div_b_safe;
    div_q      = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    div_r      = a_neg ? (32'd0 - ur) : ur;
  end

  // Next-state: accept ops in IDLE, count down and commit in RUN
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;

    unique case (state)
      IDLE: begin
        unique case (bus.md_op)
          OP_MULT: begin
            pend_hi_d = prod_s[63:32];
            pend_lo_d = prod_s[31:0];
            cnt_d     = MULT_LOAD;
          end
          OP_MULTU: begin
            pend_hi_d = prod_u[63:32];
            pend_lo_d = prod_u[31:0];
            cnt_d     = MULT_LOAD;
          end
          OP_DIV, OP_DIVU: begin
            // Divide by zero still takes the full latency but leaves HI/LO as-is
            if (bus.rt_val == '0) begin
              pend_hi_d = hi_q;
              pend_lo_d = lo_q;
            end else begin
              pend_hi_d = div_r;
              pend_lo_d = div_q;
            end
            cnt_d = DIV_LOAD;
          end
          OP_MTHI: hi_d = bus.rs_val;
          OP_MTLO: lo_d = bus.rs_val;
          default: ;
        endcase
      end
      RUN: begin
        // Any op presented while running is dropped; stall holds it in D
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
      default: ;
    endcase
  end

  // State registers with asynchronous abort on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.stall = (state == RUN) || start_op;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with hand-computed HI/LO expectations.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_md_sequencer;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  md_sequencer_if bus ();

  md_sequencer #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue a start, measure busy length, then check committed HI/LO.
  // old_hi/old_lo are the values that must persist while busy.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    @(negedge clk);
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    #1;
    chk({tag, "_stall_issue"}, 32'(bus.stall), 32'd1);
    @(negedge clk);
    bus.md_op = 3'd0;
    #1;
    chk({tag, "_hi_hold"}, bus.hi, old_hi);
    chk({tag, "_lo_hold"}, bus.lo, old_lo);
    chk({tag, "_stall_busy"}, 32'(bus.stall), 32'd1);
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'(n));
    chk({tag, "_hi"}, bus.hi, exp_hi);
    chk({tag, "_lo"}, bus.lo, exp_lo);
    chk({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
  endtask

  // One-edge move to HI (op 5) or LO (op 6)
  task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] v,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    bus.md_op  = op;
    bus.rs_val = v;
    #1;
    chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.md_op = 3'd0;
    #1;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hi"}, bus.hi, exp_hi);
    chk({tag, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    bus.md_op  = 3'd0;
    bus.rs_val = '0;
    bus.rt_val = '0;

    @(negedge clk);
    #1;
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_hi",    bus.hi, 32'd0);
    chk("rst_lo",    bus.lo, 32'd0);
    reset = 1'b0;

    // -1 * 2 = -2
    run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 5,
           32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    // 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE);
    // -7 / 2 = -3 rem -1
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10,
           32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    // Overflow corner: most-negative / -1
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0, 32'h8000_0000);
    // 7 / -2 = -3 rem 1
    run_op("div_negb", 3'd3, 32'd7, 32'hFFFF_FFFE, 10,
           32'h0, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFD);
    // Back-to-back unsigned divide: 100 / 7 = 14 rem 2
    run_op("divu", 3'd4, 32'd100, 32'd7, 10,
           32'h0000_0001, 32'hFFFF_FFFD, 32'd2, 32'd14);

    move_to("mthi", 3'd5, 32'h11, 32'h11, 32'd14);
    move_to("mtlo", 3'd6, 32'h22, 32'h11, 32'h22);

    // Reserved op is a no-op and does not stall
    @(negedge clk);
    bus.md_op  = 3'd7;
    bus.rs_val = 32'hDEAD_BEEF;
    #1;
    chk("rsvd_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.md_op = 3'd0;
    #1;
    chk("rsvd_busy", 32'(bus.busy), 32'd0);
    chk("rsvd_hi", bus.hi, 32'h11);
    chk("rsvd_lo", bus.lo, 32'h22);

    // Divide by zero keeps HI/LO after the full latency
    run_op("divu_z", 3'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22, 32'h11, 32'h22);

    // mtlo issued mid-multiply must be dropped
    begin
      int cyc;
      @(negedge clk);
      bus.md_op  = 3'd1;
      bus.rs_val = 32'd3;
      bus.rt_val = 32'd4;
      @(negedge clk);
      bus.md_op = 3'd0;
      @(negedge clk);
      @(negedge clk);
      // busy cycle 3
      bus.md_op  = 3'd6;
      bus.rs_val = 32'h55;
      #1;
      chk("mtlo_busy_stall", 32'(bus.stall), 32'd1);
      @(negedge clk);
      bus.md_op = 3'd0;
      #1;
      chk("mtlo_busy_lo_hold", bus.lo, 32'h22);
      cyc = 0;
      while (bus.busy && cyc < 40) begin
        cyc++;
        @(negedge clk);
        #1;
      end
      chk("mtlo_busy_rest", 32'(cyc), 32'd2);
      chk("mtlo_busy_hi", bus.hi, 32'h0);
      chk("mtlo_busy_lo", bus.lo, 32'h0000_000C);
    end

    // Asynchronous reset aborts a divide at busy cycle 2
    @(negedge clk);
    bus.md_op  = 3'd4;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd3;
    @(negedge clk);
    bus.md_op = 3'd0;
    @(negedge clk);
    #1;
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hi",   bus.hi, 32'h0);
    chk("abort_lo",   bus.lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mult_post", 3'd1, 32'd6, 32'd7, 5, 32'h0, 32'h0, 32'h0, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
